// File: rtl/conv_pkg.sv
// Shared convolution-path definitions: pixel width, window geometry and
// row-major window index constants used by the window generator and MAC stage.
package conv_pkg;

    localparam int DATA_W = 8;
    localparam int WIN_K  = 3;

    // Row-major 3x3 window positions
    localparam int WIN_TL = 0;
    localparam int WIN_TC = 1;
    localparam int WIN_TR = 2;
    localparam int WIN_ML = 3;
    localparam int WIN_MC = 4;
    localparam int WIN_MR = 5;
    localparam int WIN_BL = 6;
    localparam int WIN_BC = 7;
    localparam int WIN_BR = 8;

    typedef logic signed [DATA_W-1:0] pix_t;

endpackage

// File: rtl/line_fifo.sv
// line_fifo: fixed delay of DEPTH enabled samples with asynchronous clear.
// Output is the sample written DEPTH enables ago. For large DEPTH this maps
// onto an SRAM with a circular pointer; here it is a plain register chain so
// the whole buffer clears on reset.
module line_fifo #(
    parameter int          DATA_W = 8,
    parameter int unsigned DEPTH  = 32
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic [DATA_W-1:0] d_i,
    output logic [DATA_W-1:0] q_o
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Shift the chain by one position per enabled sample
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (en_i) begin
            mem[0] <= d_i;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                mem[i] <= mem[i-1];
            end
        end
    end

    assign q_o = mem[DEPTH-1];

endmodule

// File: rtl/line_window_3x3.sv
// line_window_3x3: streaming 3x3 sliding-window generator (valid convolution,
// no padding). Two cascaded line_fifo instances supply rows r-1 and r-2; the
// window register shifts left on each accepted pixel.
// Optional feature: define LINE_WINDOW_STRIDE2_EN to emit only windows whose
// top-left corner sits on even row and column (stride 2).
module line_window_3x3
    import conv_pkg::*;
#(
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32,
    parameter int DATA_W = conv_pkg::DATA_W
) (
    input  logic                     clk_i,
    input  logic                     rst_n,
    input  logic                     pix_valid_i,
    input  logic                     sof_i,
    input  logic signed [DATA_W-1:0] pix_i,
    output logic                     win_valid_o,
    output logic signed [DATA_W-1:0] win_0_o,
    output logic signed [DATA_W-1:0] win_1_o,
    output logic signed [DATA_W-1:0] win_2_o,
    output logic signed [DATA_W-1:0] win_3_o,
    output logic signed [DATA_W-1:0] win_4_o,
    output logic signed [DATA_W-1:0] win_5_o,
    output logic signed [DATA_W-1:0] win_6_o,
    output logic signed [DATA_W-1:0] win_7_o,
    output logic signed [DATA_W-1:0] win_8_o
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    logic [CW-1:0] col, cur_col;
    logic [RW-1:0] row, cur_row;
    logic          in_region;

    logic [DATA_W-1:0] lb1_out, lb2_out;
    logic [DATA_W-1:0] win [WIN_K*WIN_K];
    logic              win_valid;

    // Position of the incoming pixel; sof forces it to (0,0)
    always_comb begin
        cur_col   = sof_i ? '0 : col;
        cur_row   = sof_i ? '0 : row;
        in_region = (cur_row >= ROW_TWO) && (cur_col >= COL_TWO);
`ifdef LINE_WINDOW_STRIDE2_EN
        // (r-2) and (c-2) even is the same as r and c even
        in_region = in_region && !cur_row[0] && !cur_col[0];
`endif
    end

    // Raster counters advance from the current position on accepted pixels
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (pix_valid_i) begin
            if (cur_col == COL_LAST) begin
                col <= '0;
                row <= (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
            end else begin
                col <= cur_col + CW'(1);
                row <= cur_row;
            end
        end
    end

    line_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (IMG_W)
    ) u_lb1 (
        .clk_i (clk_i),
        .rst_n (rst_n),
        .en_i  (pix_valid_i),
        .d_i   (pix_i),
        .q_o   (lb1_out)
    );

    line_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (IMG_W)
    ) u_lb2 (
        .clk_i (clk_i),
        .rst_n (rst_n),
        .en_i  (pix_valid_i),
        .d_i   (lb1_out),
        .q_o   (lb2_out)
    );

    // Window shifts one column left; new right column is {lb2, lb1, pix}
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < WIN_K*WIN_K; k++) begin
                win[k] <= '0;
            end
        end else if (pix_valid_i) begin
            for (int unsigned r = 0; r < WIN_K; r++) begin
                for (int unsigned c = 0; c < WIN_K-1; c++) begin
                    win[r*WIN_K+c] <= win[r*WIN_K+c+1];
                end
            end
            win[WIN_TR] <= lb2_out;
            win[WIN_MR] <= lb1_out;
            win[WIN_BR] <= pix_i;
        end
    end

    // Window valid flag, registered alongside the window data
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            win_valid <= 1'b0;
        end else begin
            win_valid <= pix_valid_i && in_region;
        end
    end

    assign win_valid_o = win_valid;
    assign win_0_o     = win[WIN_TL];
    assign win_1_o     = win[WIN_TC];
    assign win_2_o     = win[WIN_TR];
    assign win_3_o     = win[WIN_ML];
    assign win_4_o     = win[WIN_MC];
    assign win_5_o     = win[WIN_MR];
    assign win_6_o     = win[WIN_BL];
    assign win_7_o     = win[WIN_BC];
    assign win_8_o     = win[WIN_BR];

endmodule

// File: tb/tb_line_window_3x3.sv
// Self-checking bench for line_window_3x3: 4x4 table-driven frames plus
// hand-written sequences (idle toggling, back-to-back frames, mid-frame sof,
// mid-frame reset) and a 6x6 frame for the stride option.
module tb_line_window_3x3;

    typedef struct {
        logic       sof;
        logic [7:0] pix;
        logic       exp_v;
        int         base;
    } vec_t;

    logic              clk_i = 1'b0;
    logic              rst_n = 1'b0;
    logic              pv    = 1'b0;
    logic              sof   = 1'b0;
    logic signed [7:0] pix   = '0;
    logic              wv;
    logic signed [7:0] w [9];

    logic              pv6  = 1'b0;
    logic              sof6 = 1'b0;
    logic signed [7:0] pix6 = '0;
    logic              wv6;
    logic signed [7:0] w6 [9];

    int   errors = 0;
    int   checks = 0;
    int   nwin   = 0;
    vec_t tbl [16];

    always #5 clk_i = ~clk_i;

    line_window_3x3 #(.IMG_W(4), .IMG_H(4), .DATA_W(8)) dut (
        .clk_i(clk_i), .rst_n(rst_n), .pix_valid_i(pv), .sof_i(sof), .pix_i(pix),
        .win_valid_o(wv),
        .win_0_o(w[0]), .win_1_o(w[1]), .win_2_o(w[2]),
        .win_3_o(w[3]), .win_4_o(w[4]), .win_5_o(w[5]),
        .win_6_o(w[6]), .win_7_o(w[7]), .win_8_o(w[8])
    );

    line_window_3x3 #(.IMG_W(6), .IMG_H(6), .DATA_W(8)) dut6 (
        .clk_i(clk_i), .rst_n(rst_n), .pix_valid_i(pv6), .sof_i(sof6), .pix_i(pix6),
        .win_valid_o(wv6),
        .win_0_o(w6[0]), .win_1_o(w6[1]), .win_2_o(w6[2]),
        .win_3_o(w6[3]), .win_4_o(w6[4]), .win_5_o(w6[5]),
        .win_6_o(w6[6]), .win_7_o(w6[7]), .win_8_o(w6[8])
    );

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected window for top-left pixel value base in an image of given width
    function automatic logic [71:0] exp_win(input int base, input int width);
        logic [71:0] res;
        int          v;
        res = '0;
        for (int k = 0; k < 9; k++) begin
            v = base + (k / 3) * width + (k % 3);
            res[(8-k)*8 +: 8] = v[7:0];
        end
        return res;
    endfunction

    function automatic logic [71:0] act_win();
        logic [71:0] res;
        for (int k = 0; k < 9; k++) res[(8-k)*8 +: 8] = w[k];
        return res;
    endfunction

    function automatic logic [71:0] act_win6();
        logic [71:0] res;
        for (int k = 0; k < 9; k++) res[(8-k)*8 +: 8] = w6[k];
        return res;
    endfunction

    // One 4x4 frame from the table; optional idle (with stray sof) after each pixel
    task automatic run_frame(input bit toggle, input bit first_sof);
        for (int i = 0; i < 16; i++) begin
            pv  = 1'b1;
            sof = (i == 0) && first_sof;
            pix = tbl[i].pix;
            @(negedge clk_i);
            chk("valid", 72'(wv), 72'(tbl[i].exp_v));
            if (wv) nwin++;
            if (tbl[i].exp_v) chk("window", act_win(), exp_win(tbl[i].base, 4));
            if (toggle) begin
                pv  = 1'b0;
                sof = 1'b1;
                pix = 8'sh5A;
                @(negedge clk_i);
                chk("idle_valid", 72'(wv), 72'd0);
                if (tbl[i].exp_v) chk("idle_hold", act_win(), exp_win(tbl[i].base, 4));
            end
        end
        pv  = 1'b0;
        sof = 1'b0;
    endtask

    initial begin
        // 4x4 frame, P(r,c)=4r+c; windows at (2,2),(2,3),(3,2),(3,3)
        tbl[0]  = '{1'b0, 8'd0,  1'b0, 0};
        tbl[1]  = '{1'b0, 8'd1,  1'b0, 0};
        tbl[2]  = '{1'b0, 8'd2,  1'b0, 0};
        tbl[3]  = '{1'b0, 8'd3,  1'b0, 0};
        tbl[4]  = '{1'b0, 8'd4,  1'b0, 0};
        tbl[5]  = '{1'b0, 8'd5,  1'b0, 0};
        tbl[6]  = '{1'b0, 8'd6,  1'b0, 0};
        tbl[7]  = '{1'b0, 8'd7,  1'b0, 0};
        tbl[8]  = '{1'b0, 8'd8,  1'b0, 0};
        tbl[9]  = '{1'b0, 8'd9,  1'b0, 0};
        tbl[10] = '{1'b0, 8'd10, 1'b1, 0};
        tbl[11] = '{1'b0, 8'd11, 1'b1, 1};
        tbl[12] = '{1'b0, 8'd12, 1'b0, 0};
        tbl[13] = '{1'b0, 8'd13, 1'b0, 0};
        tbl[14] = '{1'b0, 8'd14, 1'b1, 4};
        tbl[15] = '{1'b0, 8'd15, 1'b1, 5};

        // Reset state
        @(negedge clk_i);
        @(negedge clk_i);
        chk("rst_valid", 72'(wv), 72'd0);
        chk("rst_window", act_win(), 72'd0);
        rst_n = 1'b1;

        // Continuous frame, no sof after reset
        nwin = 0;
        run_frame(1'b0, 1'b0);
        chk("count_cont", 72'(nwin), 72'd4);

        // Valid toggled every other cycle, stray sof on idles
        nwin = 0;
        run_frame(1'b1, 1'b0);
        chk("count_toggle", 72'(nwin), 72'd4);

        // Two back-to-back frames without sof
        nwin = 0;
        run_frame(1'b0, 1'b0);
        run_frame(1'b0, 1'b0);
        chk("count_b2b", 72'(nwin), 72'd8);

        // Six pixels of a frame, then sof restarts the counters
        for (int i = 0; i < 6; i++) begin
            pv  = 1'b1;
            pix = tbl[i].pix;
            @(negedge clk_i);
            chk("pre_sof_valid", 72'(wv), 72'd0);
        end
        nwin = 0;
        run_frame(1'b0, 1'b1);
        chk("count_sof", 72'(nwin), 72'd4);

        // Reset asserted mid-row 2, then a fresh frame without sof
        for (int i = 0; i < 10; i++) begin
            pv  = 1'b1;
            pix = tbl[i].pix;
            @(negedge clk_i);
        end
        pv = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", 72'(wv), 72'd0);
        chk("midrst_window", act_win(), 72'd0);
        @(negedge clk_i);
        chk("midrst_window_hold", act_win(), 72'd0);
        rst_n = 1'b1;
        nwin = 0;
        run_frame(1'b0, 1'b0);
        chk("count_after_rst", 72'(nwin), 72'd4);

        // 6x6 frame, P(r,c)=6r+c
        nwin = 0;
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 6; c++) begin
                bit ev;
                pv6  = 1'b1;
                pix6 = 8'(6 * r + c);
                @(negedge clk_i);
                ev = (r >= 2) && (c >= 2);
`ifdef LINE_WINDOW_STRIDE2_EN
                ev = ev && (r % 2 == 0) && (c % 2 == 0);
`endif
                chk("valid6", 72'(wv6), 72'(ev));
                if (wv6) nwin++;
                if (ev) chk("window6", act_win6(), exp_win(6 * (r - 2) + (c - 2), 6));
            end
        end
        pv6 = 1'b0;
`ifdef LINE_WINDOW_STRIDE2_EN
        chk("count6", 72'(nwin), 72'd4);
`else
        chk("count6", 72'(nwin), 72'd16);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
